// File: rtl/asrv32_mem_arbiter_if.sv
// Requester and RAM-side signal bundle of the asrv32 unified-memory arbiter.
// The arbiter connects through the slave modport; requesters and the RAM use master.
interface asrv32_mem_arbiter_if #(
  parameter int ADDR_W = 12
);
  // Instruction-fetch requester
  logic              i_ireq;
  logic [31:0]       i_iaddr;
  logic              o_iack;
  logic [31:0]       o_irdata;
  // Load/store requester
  logic              i_dreq;
  logic              i_dwe;
  logic [31:0]       i_daddr;
  logic [3:0]        i_dwmask;
  logic [31:0]       i_dwdata;
  logic              o_dack;
  logic [31:0]       o_drdata;
  // Single-port synchronous RAM
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [3:0]        o_mem_wmask;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  modport slave (
    input  i_ireq, i_iaddr, i_dreq, i_dwe, i_daddr, i_dwmask, i_dwdata, i_mem_rdata,
    output o_iack, o_irdata, o_dack, o_drdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wmask, o_mem_wdata
  );

  modport master (
    output i_ireq, i_iaddr, i_dreq, i_dwe, i_daddr, i_dwmask, i_dwdata, i_mem_rdata,
    input  o_iack, o_irdata, o_dack, o_drdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wmask, o_mem_wdata
  );
endinterface

// File: rtl/asrv32_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// One access at a time: IDLE -> ACCESS -> (WAIT) -> RESP, all outputs registered.
module asrv32_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 1,
  parameter int ARB_MODE   = 0
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  asrv32_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);

  state_t            state, state_nxt;
  logic              pick_d;
  logic              take;
  logic              capture;
  logic              last_d;
  logic              gnt_d;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_mask;
  logic [31:0]       acc_wdata;
  logic [2:0]        cnt;
  logic              mem_en_nxt, mem_we_nxt, iack_nxt, dack_nxt;
  logic              mem_en_q, mem_we_q, iack_q, dack_q;
  logic [31:0]       irdata_q, drdata_q;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Next-state and grant decision
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    state_nxt = state;
    pick_d    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.i_ireq || bus.i_dreq) begin
          state_nxt = S_ACCESS;
          // Conflicts go to data in priority mode, else to the port not served last.
          pick_d = bus.i_dreq && (!bus.i_ireq || (ARB_MODE != 0) || !last_d);
        end
      end
      S_ACCESS: state_nxt = acc_we ? S_RESP : S_WAIT;
      S_WAIT:   if (cnt == 3'd0) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered strobes
  always_comb begin
    mem_en_nxt = 1'b0;
    mem_we_nxt = 1'b0;
    iack_nxt   = 1'b0;
    dack_nxt   = 1'b0;
    take       = (state == S_IDLE) && (state_nxt == S_ACCESS);
    capture    = (state == S_WAIT) && (cnt == 3'd0);
    if (state_nxt == S_ACCESS) begin
      mem_en_nxt = 1'b1;
      mem_we_nxt = pick_d & bus.i_dwe;
    end
    if (state_nxt == S_RESP) begin
      iack_nxt = ~gnt_d;
      dack_nxt = gnt_d;
    end
  end

  // Latched request, latency counter, read-data registers and output strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_d    <= 1'b0;
      gnt_d     <= 1'b0;
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_mask  <= 4'b0000;
      acc_wdata <= '0;
      cnt       <= 3'd0;
      irdata_q  <= '0;
      drdata_q  <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      iack_q    <= 1'b0;
      dack_q    <= 1'b0;
    end else begin
      mem_en_q <= mem_en_nxt;
      mem_we_q <= mem_we_nxt;
      iack_q   <= iack_nxt;
      dack_q   <= dack_nxt;
      if (take) begin
        gnt_d     <= pick_d;
        acc_we    <= pick_d & bus.i_dwe;
        acc_addr  <= pick_d ? bus.i_daddr[ADDR_W+1:2] : bus.i_iaddr[ADDR_W+1:2];
        acc_mask  <= pick_d ? bus.i_dwmask : 4'b0000;
        acc_wdata <= pick_d ? bus.i_dwdata : 32'd0;
      end
      if (state == S_ACCESS && !acc_we) begin
        cnt <= LAT_LOAD;
      end else if (state == S_WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (capture) begin
        if (gnt_d) drdata_q <= bus.i_mem_rdata;
        else       irdata_q <= bus.i_mem_rdata;
      end
      if (state == S_RESP) last_d <= gnt_d;
    end
  end

  // Byte-offset and out-of-range address bits carry no meaning for a word RAM
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_iaddr[1:0], bus.i_iaddr[31:ADDR_W+2],
                              bus.i_daddr[1:0], bus.i_daddr[31:ADDR_W+2]};

  assign bus.o_iack      = iack_q;
  assign bus.o_dack      = dack_q;
  assign bus.o_irdata    = irdata_q;
  assign bus.o_drdata    = drdata_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = acc_addr;
  assign bus.o_mem_wmask = acc_mask;
  assign bus.o_mem_wdata = acc_wdata;

endmodule

// File: tb/tb_asrv32_mem_arbiter.sv
// Scoreboard bench for asrv32_mem_arbiter: four instances (default, RD_LATENCY 4 and 8,
// data-priority) each with a small RAM model that drives junk outside its valid read cycle.
module tb_asrv32_mem_arbiter;

  localparam int NI = 4;

  typedef struct {
    int          cyc;
    bit          is_d;
    logic [31:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic [NI-1:0] rst_n, ireq, dreq, dwe;
  logic [31:0]   iaddr [NI];
  logic [31:0]   daddr [NI];
  logic [31:0]   dwdata [NI];
  logic [3:0]    dwmask [NI];
  logic [NI-1:0] iack, dack, en, we;
  logic [31:0]   irdata [NI];
  logic [31:0]   drdata [NI];
  logic [31:0]   mwdata [NI];
  logic [11:0]   maddr [NI];
  logic [3:0]    mmask [NI];

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb [NI][$];
  logic [31:0] last_drd [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rl_of(input int k);
    return (k == 1) ? 4 : (k == 2) ? 8 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int RL = (g == 1) ? 4 : (g == 2) ? 8 : 1;
    localparam int AM = (g == 3) ? 1 : 0;

    asrv32_mem_arbiter_if #(.ADDR_W(12)) bus ();

    asrv32_mem_arbiter #(.ADDR_W(12), .RD_LATENCY(RL), .ARB_MODE(AM)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n[g]),
      .bus     (bus)
    );

    assign bus.i_ireq   = ireq[g];
    assign bus.i_iaddr  = iaddr[g];
    assign bus.i_dreq   = dreq[g];
    assign bus.i_dwe    = dwe[g];
    assign bus.i_daddr  = daddr[g];
    assign bus.i_dwmask = dwmask[g];
    assign bus.i_dwdata = dwdata[g];
    assign iack[g]   = bus.o_iack;
    assign dack[g]   = bus.o_dack;
    assign irdata[g] = bus.o_irdata;
    assign drdata[g] = bus.o_drdata;
    assign en[g]     = bus.o_mem_en;
    assign we[g]     = bus.o_mem_we;
    assign maddr[g]  = bus.o_mem_addr;
    assign mmask[g]  = bus.o_mem_wmask;
    assign mwdata[g] = bus.o_mem_wdata;

    // RAM model: read word is visible only in cycle issue+RL
    logic [31:0] mem [0:255];
    int          issue_cyc;
    logic [31:0] rd_word;

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1111_1111;
      mem[4]    = 32'h0000_0093;
      mem[17]   = 32'h1234_5678;
      issue_cyc = -100;
      rd_word   = 32'd0;
    end

    always @(posedge clk) begin
      if (bus.o_mem_en) begin
        if (bus.o_mem_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.o_mem_wmask[b]) mem[bus.o_mem_addr[7:0]][8*b +: 8] = bus.o_mem_wdata[8*b +: 8];
        end else begin
          rd_word   = mem[bus.o_mem_addr[7:0]];
          issue_cyc = cyc;
        end
      end
    end

    assign bus.i_mem_rdata = (cyc == issue_cyc + RL) ? rd_word : {16'hBAD0, cyc[15:0]};

    // Monitor: pop the scoreboard on every ack
    logic en_prev = 1'b0;
    always @(negedge clk) begin
      if (!rst_n[g]) begin
        en_prev = 1'b0;
      end else begin
        if (bus.o_mem_en) check("mem_en_gap", 32'(en_prev), 32'd0);
        en_prev = bus.o_mem_en;
        if (bus.o_iack || bus.o_dack) begin
          if (sb[g].size() == 0) begin
            check("spurious_ack", {30'd0, bus.o_dack, bus.o_iack}, 32'd0);
          end else begin
            exp_t e;
            e = sb[g].pop_front();
            check("ack_port", {30'd0, bus.o_dack, bus.o_iack}, e.is_d ? 32'd2 : 32'd1);
            check("ack_cycle", 32'(cyc), 32'(e.cyc));
            check("ack_rdata", e.is_d ? bus.o_drdata : bus.o_irdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic check_zero(input int k);
    check("rst_iack",   32'(iack[k]), 32'd0);
    check("rst_dack",   32'(dack[k]), 32'd0);
    check("rst_mem_en", 32'(en[k]),   32'd0);
    check("rst_mem_we", 32'(we[k]),   32'd0);
    check("rst_addr",   32'(maddr[k]), 32'd0);
    check("rst_wmask",  32'(mmask[k]), 32'd0);
    check("rst_wdata",  mwdata[k], 32'd0);
    check("rst_irdata", irdata[k], 32'd0);
    check("rst_drdata", drdata[k], 32'd0);
  endtask

  // One uncontested request; rd is the word the RAM model holds for a read
  task automatic do_req(input int k, input bit d, input bit w, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wd, input logic [31:0] rd);
    int          lat;
    int          c0;
    bit          got;
    logic [31:0] exp_rd;
    lat = w ? 2 : 2 + rl_of(k);
    @(posedge clk); #1;
    c0 = cyc;
    if (d) begin
      dreq[k] = 1'b1; dwe[k] = w; daddr[k] = addr; dwmask[k] = mask; dwdata[k] = wd;
    end else begin
      ireq[k] = 1'b1; iaddr[k] = addr;
    end
    exp_rd = (d && w) ? last_drd[k] : rd;
    if (d && !w) last_drd[k] = rd;
    sb[k].push_back('{c0 + lat, d, exp_rd});
    got = 1'b0;
    for (int c = 0; c <= lat + 4 && !got; c++) begin
      @(negedge clk);
      check("mem_en_slot", 32'(en[k]), 32'(c == 1));
      if (c == 1) begin
        check("mem_addr",  32'(maddr[k]), (addr >> 2) & 32'h0000_0FFF);
        check("mem_we",    32'(we[k]),    32'(d && w));
        check("mem_wmask", 32'(mmask[k]), d ? 32'(mask) : 32'd0);
        if (d && w) check("mem_wdata", mwdata[k], wd);
        // Held inputs change after the grant; the latched access must not follow
        iaddr[k] = ~iaddr[k]; daddr[k] = ~daddr[k]; dwmask[k] = ~dwmask[k];
        dwdata[k] = ~dwdata[k]; dwe[k] = ~dwe[k];
      end
      got = iack[k] | dack[k];
    end
    check("ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    ireq[k] = 1'b0; dreq[k] = 1'b0;
  endtask

  // Both requests held from reset release for four back-to-back grants
  task automatic conflict(input int k, input bit prio);
    int c0;
    @(posedge clk); #1;
    rst_n[k] = 1'b0;
    ireq[k] = 1'b1; iaddr[k] = 32'h10;
    dreq[k] = 1'b1; daddr[k] = 32'h44; dwe[k] = 1'b0; dwmask[k] = 4'h0; dwdata[k] = 32'd0;
    @(posedge clk); #1;
    rst_n[k] = 1'b1;
    last_drd[k] = 32'd0;
    c0 = cyc;
    sb[k].push_back('{c0 + 3,  1'b1, 32'h1234_5678});
    sb[k].push_back('{c0 + 7,  prio, prio ? 32'h1234_5678 : 32'h0000_0093});
    sb[k].push_back('{c0 + 11, 1'b1, 32'h1234_5678});
    sb[k].push_back('{c0 + 15, 1'b0, 32'h0000_0093});
    last_drd[k] = 32'h1234_5678;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("conflict_en", 32'(en[k]), 32'((c % 4) == 1));
      if (prio && c == 11) begin
        @(posedge clk); #1;
        dreq[k] = 1'b0;
      end
    end
    @(posedge clk); #1;
    ireq[k] = 1'b0; dreq[k] = 1'b0;
  endtask

  task automatic reset_mid_wait();
    @(posedge clk); #1;
    ireq[1] = 1'b1; iaddr[1] = 32'h10;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n[1] = 1'b0;
    #1;
    check_zero(1);
    ireq[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    last_drd[1] = 32'd0;
    repeat (8) @(posedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = '0; ireq = '0; dreq = '0; dwe = '0;
    for (int k = 0; k < NI; k++) begin
      iaddr[k] = 32'd0; daddr[k] = 32'd0; dwdata[k] = 32'd0; dwmask[k] = 4'h0;
      last_drd[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = '1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_zero(k);

    // Default instance: fetch, load, masked store, zero-mask store, ignored address bits
    do_req(0, 1'b0, 1'b0, 32'h0000_0010, 4'h0,    32'd0,         32'h0000_0093);
    do_req(0, 1'b1, 1'b0, 32'h0000_0044, 4'hF,    32'd0,         32'h1234_5678);
    do_req(0, 1'b1, 1'b1, 32'h0000_0020, 4'b0011, 32'hDEAD_BEEF, 32'd0);
    do_req(0, 1'b1, 1'b0, 32'h0000_0020, 4'hF,    32'd0,         32'h1111_BEEF);
    do_req(0, 1'b0, 1'b0, 32'hFFFF_C013, 4'h0,    32'd0,         32'h0000_0093);
    do_req(0, 1'b1, 1'b1, 32'h0000_0044, 4'b0000, 32'hFFFF_FFFF, 32'd0);
    do_req(0, 1'b1, 1'b0, 32'h0000_0044, 4'hF,    32'd0,         32'h1234_5678);

    // Long latency: ack in cycle 10, data sampled at end of cycle 9
    do_req(2, 1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'd0, 32'h0000_0093);
    do_req(2, 1'b1, 1'b0, 32'h0000_0044, 4'hF, 32'd0, 32'h1234_5678);

    // Latency 4: normal read, reset mid-WAIT, then recovery
    do_req(1, 1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'd0, 32'h0000_0093);
    reset_mid_wait();
    do_req(1, 1'b0, 1'b0, 32'h0000_0044, 4'h0, 32'd0, 32'h1234_5678);

    // Conflicts: round-robin (last grant before reset was data) and data priority
    conflict(0, 1'b0);
    conflict(3, 1'b1);

    repeat (6) @(posedge clk);
    for (int k = 0; k < NI; k++) check("sb_drain", 32'(sb[k].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
